// File: rtl/tx_pkg.sv
// ============================================================================
// tx_pkg : shared sizing defaults and controller state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package tx_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tx_sample_ram.sv
// ============================================================================
// tx_sample_ram : simple dual-port sample buffer, registered read port
// Rev 1.0
// ============================================================================
`default_nettype none

module tx_sample_ram #(
  parameter int DATA_W = tx_pkg::DATA_W,
  parameter int ADDR_W = tx_pkg::ADDR_W,
  parameter int DEPTH  = tx_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] r_doutb = '0;

  always_ff @(posedge clk) begin
    if (wea) begin
      r_mem[addra] <= dina;
    end
  end

  // Write-first on a same-address collision so a frame started in the same
  // cycle as a write to address 0 plays the freshly written sample.
  always_ff @(posedge clk) begin
    if (enb) begin
      r_doutb <= (wea && (addra == addrb)) ? dina : r_mem[addrb];
    end
  end

  assign doutb = r_doutb;

endmodule

`default_nettype wire

// File: rtl/tx_frame_player.sv
// ============================================================================
// tx_frame_player : plays a buffered frame out over valid/ready, 1 sample/clk
// Rev 1.0
// ============================================================================
`default_nettype none

module tx_frame_player #(
  parameter int DATA_W = tx_pkg::DATA_W,
  parameter int ADDR_W = tx_pkg::ADDR_W,
  parameter int DEPTH  = tx_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  input  logic              tx_ready
);

  import tx_pkg::*;

  localparam logic [ADDR_W:0] c_len_max = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_one     = (ADDR_W+1)'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_rd_cnt;
  logic [ADDR_W:0]   r_tx_cnt;
  logic              r_out_v;
  logic              r_pf_v;
  logic              r_pend;
  logic              r_done;
  logic [DATA_W-1:0] r_out;
  logic [DATA_W-1:0] r_pf;
  logic [DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W:0]   w_len_clamped;
  logic [1:0]        w_stored;
  logic              w_busy;
  logic              w_abort;
  logic              w_start_ok;
  logic              w_issue_play;
  logic              w_issue;
  logic              w_pop;
  logic              w_last;
  logic              w_final;
  logic              w_wr_en;

  assign w_busy        = (r_state != IDLE);
  assign w_abort       = abort && w_busy;
  assign w_len_clamped = (frame_len > c_len_max) ? c_len_max : frame_len;
  assign w_start_ok    = (r_state == IDLE) && start && !abort && (frame_len != '0);
  assign w_pop         = r_out_v && tx_ready;
  assign w_last        = r_out_v && (r_tx_cnt == (r_len - c_one));
  assign w_final       = (r_state == DRAIN) && w_pop && w_last;
  assign w_wr_en       = wr_en && !w_busy;

  // Samples held after this edge (output + prefetch + landing read). A new
  // read is only issued if it is guaranteed a slot even with no pop next cycle.
  assign w_stored      = 2'(r_out_v) + 2'(r_pf_v) + 2'(r_pend) - 2'(w_pop);
  assign w_issue_play  = ((r_state == PRIME) || (r_state == PLAY)) && !abort &&
                         (r_rd_cnt != r_len) && (w_stored <= 2'd1);
  assign w_issue       = w_start_ok || w_issue_play;
  assign w_rd_addr     = w_start_ok ? '0 : r_rd_cnt[ADDR_W-1:0];

  tx_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .wea   (w_wr_en),
    .addra (wr_addr),
    .dina  (wr_data),
    .enb   (w_issue),
    .addrb (w_rd_addr),
    .doutb (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = w_busy;
    done        = r_done;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = PRIME;
      PRIME:   w_state_nxt = (r_len == c_one) ? DRAIN : PLAY;
      PLAY:    if (r_rd_cnt == r_len) w_state_nxt = DRAIN;
      DRAIN:   if (w_final) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len    <= '0;
      r_rd_cnt <= '0;
      r_tx_cnt <= '0;
      r_out_v  <= 1'b0;
      r_pf_v   <= 1'b0;
      r_pend   <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
      r_pf     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_out_v  <= 1'b0;
        r_pf_v   <= 1'b0;
        r_pend   <= 1'b0;
        r_rd_cnt <= '0;
        r_tx_cnt <= '0;
      end else begin
        if (w_start_ok) begin
          r_len    <= w_len_clamped;
          r_tx_cnt <= '0;
        end
        if (w_issue) begin
          r_rd_cnt <= w_start_ok ? c_one : (r_rd_cnt + c_one);
        end
        r_pend <= w_issue;
        if (w_pop) begin
          r_tx_cnt <= r_tx_cnt + c_one;
        end
        // Output register refills from prefetch first to keep address order.
        if (!r_out_v || w_pop) begin
          if (r_pf_v) begin
            r_out   <= r_pf;
            r_out_v <= 1'b1;
            r_pf_v  <= r_pend;
            if (r_pend) begin
              r_pf <= w_rd_data;
            end
          end else if (r_pend) begin
            r_out   <= w_rd_data;
            r_out_v <= 1'b1;
          end else begin
            r_out_v <= 1'b0;
          end
        end else if (r_pend) begin
          r_pf   <= w_rd_data;
          r_pf_v <= 1'b1;
        end
        if (w_final) begin
          r_done   <= 1'b1;
          r_rd_cnt <= '0;
          r_tx_cnt <= '0;
        end
      end
    end
  end

  assign tx_data  = r_out;
  assign tx_valid = r_out_v;
  assign tx_last  = w_last;

endmodule

`default_nettype wire

// File: tb/tb_tx_frame_player.sv
// ============================================================================
// tb_tx_frame_player : randomized frames checked against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tx_frame_player;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  frame_len;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;

  tx_frame_player dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_len (frame_len),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffer image, queue of samples still owed downstream.
  logic [15:0] mem_m [128];
  logic [15:0] q [$];
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_first_due = 0;
  int          cyc = 0;
  bit          ready_always = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data;
  logic        prev_last;
  bit          hs;
  bit          was_busy;
  int          mlen;

  int          f_hs, f_start, f_done;
  logic [15:0] f_first, f_last;
  logic [15:0] f_data [128];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_valid", tx_valid, 0);
      chk("reset_last", tx_last, 0);
      chk("reset_data", tx_data, 0);
      q.delete();
      m_busy = 0;
      m_done = 0;
      prev_stall = 0;
    end else begin
      hs = tx_valid && tx_ready;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (!m_busy)                chk("idle_valid", tx_valid, 0);
      else if (cyc < m_first_due) chk("early_valid", tx_valid, 0);
      else if (cyc == m_first_due) chk("first_valid_latency", tx_valid, 1);
      else if (ready_always)      chk("no_bubble", tx_valid, 1);
      if (prev_stall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, prev_data);
        chk("stall_last", tx_last, prev_last);
      end
      was_busy = m_busy;
      m_done = 0;
      if (hs) begin
        if (q.size() == 0) begin
          chk("unexpected_handshake", tx_valid, 0);
        end else begin
          chk("data", tx_data, q[0]);
          chk("last", tx_last, (q.size() == 1));
          if (f_hs == 0) f_first = tx_data;
          if (f_hs < 128) f_data[f_hs] = tx_data;
          f_last = tx_data;
          f_hs++;
          void'(q.pop_front());
          if (q.size() == 0 && was_busy && !abort) begin
            m_busy = 0;
            m_done = 1;
            f_done = cyc + 1;
          end
        end
      end
      if (was_busy && abort) begin
        q.delete();
        m_busy = 0;
        m_done = 0;
      end
      prev_stall = tx_valid && !tx_ready && !abort;
      prev_data  = tx_data;
      prev_last  = tx_last;
      if (!was_busy && wr_en) mem_m[wr_addr] = wr_data;
      if (!was_busy && start && !abort) begin
        mlen = (frame_len > 8'd128) ? 128 : int'(frame_len);
        if (mlen > 0) begin
          for (int i = 0; i < mlen; i++) q.push_back(mem_m[i]);
          m_busy = 1;
          m_first_due = cyc + 2;
          f_start = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // mode 0: tx_ready held high; mode 1: random tx_ready.
  task automatic run_frame(input int len, input int mode, input int midwr_at,
                           input int abort_at, input bit swr,
                           input logic [6:0] swa, input logic [15:0] swd);
    int n;
    f_hs = 0; f_done = 0; f_start = 0;
    ready_always = (mode == 0);
    tx_ready  = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    start     = 1'b1;
    frame_len = 8'(len);
    wr_en = swr; wr_addr = swa; wr_data = swd;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    n = 0;
    while (m_busy && n < 1000) begin
      n++;
      if (mode != 0) tx_ready = 1'($urandom_range(0, 1));
      wr_en   = (n == midwr_at);
      wr_addr = 7'd2;
      wr_data = 16'hAAAA;
      abort   = (n == abort_at);
      tick();
    end
    abort = 1'b0; wr_en = 1'b0; tx_ready = 1'b0; ready_always = 0;
    if (n >= 1000) begin
      vectors++;
      errors++;
      $display("FAIL frame_timeout: frame still busy after %0d cycles, required done", n);
    end
  endtask

  initial begin
    int len, mode, ab, mw, nw;
    for (int i = 0; i < 128; i++) mem_m[i] = 16'h0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    frame_len = '0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic 8-sample frame, downstream always ready.
    for (int i = 0; i < 8; i++) wr(7'(i), 16'h1000 + 16'(i));
    run_frame(8, 0, 0, 0, 1'b0, 7'd0, 16'h0);
    chk("t1_count", f_hs, 8);
    chk("t1_first", f_first, 16'h1000);
    chk("t1_last", f_last, 16'h1007);
    chk("t1_done_latency", f_done - f_start, 10);
    tick();

    // Same frame with random back-pressure.
    run_frame(8, 1, 0, 0, 1'b0, 7'd0, 16'h0);
    chk("t2_count", f_hs, 8);
    chk("t2_sample5", f_data[5], 16'h1005);
    chk("t2_last", f_last, 16'h1007);

    // Zero-length start is ignored; oversize length clamps to the full buffer.
    run_frame(0, 0, 0, 0, 1'b0, 7'd0, 16'h0);
    repeat (3) tick();
    chk("t3_len0_count", f_hs, 0);
    wr(7'd127, 16'hBEEF);
    run_frame(200, 0, 0, 0, 1'b0, 7'd0, 16'h0);
    chk("t3_clamp_count", f_hs, 128);
    chk("t3_clamp_last", f_last, 16'hBEEF);
    chk("t3_done_latency", f_done - f_start, 130);

    // Abort after the third handshake, then replay from sample 0.
    for (int i = 0; i < 16; i++) wr(7'(i), 16'h2000 + 16'(i));
    f_hs = 0; f_done = 0;
    ready_always = 1; tx_ready = 1'b1; start = 1'b1; frame_len = 8'd16;
    tick();
    start = 1'b0;
    repeat (4) tick();
    ready_always = 0; tx_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    chk("t4_abort_count", f_hs, 3);
    chk("t4_abort_nodone", f_done, 0);
    run_frame(16, 0, 0, 0, 1'b0, 7'd0, 16'h0);
    chk("t4_replay_first", f_first, 16'h2000);
    chk("t4_replay_last", f_last, 16'h200F);

    // Writes while busy are dropped; a write alongside start is played.
    run_frame(16, 1, 3, 0, 1'b0, 7'd0, 16'h0);
    chk("t5_busy_write_dropped", f_data[2], 16'h2002);
    run_frame(16, 0, 0, 0, 1'b1, 7'd0, 16'h5555);
    chk("t5_start_write_addr0", f_first, 16'h5555);
    run_frame(4, 0, 0, 0, 1'b1, 7'd2, 16'h5A5A);
    chk("t5_start_write_addr2", f_data[2], 16'h5A5A);

    // Asynchronous reset in the middle of playback, then a 1-sample frame.
    ready_always = 1; tx_ready = 1'b1; start = 1'b1; frame_len = 8'd16;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", tx_valid, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_data", tx_data, 0);
    chk("t6_async_last", tx_last, 0);
    ready_always = 0; tx_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(1, 0, 0, 0, 1'b0, 7'd0, 16'h0);
    chk("t6_single_count", f_hs, 1);
    chk("t6_single_data", f_first, 16'h5555);
    chk("t6_single_done_latency", f_done - f_start, 3);

    // Randomized frames: lengths, back-pressure, aborts, writes.
    for (int it = 0; it < 24; it++) begin
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) wr(7'($urandom_range(0, 31)), 16'($urandom));
      len  = ($urandom_range(0, 9) == 0) ? $urandom_range(129, 255) : $urandom_range(0, 24);
      mode = $urandom_range(0, 1);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      mw   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      run_frame(len, mode, mw, ab, 1'($urandom_range(0, 1)),
                7'($urandom_range(0, 7)), 16'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
